rr_reg_arbiter: RTL
===================

// Module: rr_reg_arbiter
// PURPOSE
// - Round-robin arbiter that shares one DATA_W-bit D-register between N_REQ requesters.
// - Each requester raises req; the arbiter grants one at a time and loads that
//   requester's wdata into the shared register q (complement on q_bar) every owned cycle.
// - A HOLD_MAX cycle limit bounds each grant, which guarantees fairness.
// - Sits between requester logic and the shared state register; sequences all writes to it.
// PARAMETERS
// - N_REQ     4   number of requesters (2..8)
// - DATA_W    8   width of the shared register
// - HOLD_MAX  4   max loads per grant before forced release (>=1)
// PORTS
// - clk    in   1              system clock; all state updates on posedge
// - rst    in   1              synchronous, active-high reset
// - req    in   N_REQ          request vector, bit i = requester i
// - wdata  in   N_REQ*DATA_W   packed data; requester i at [i*DATA_W +: DATA_W]
// - gnt    out  N_REQ          one-hot grant (registered), all-zero when idle
// - q      out  DATA_W         shared register value
// - q_bar  out  DATA_W         ~q, always exact complement
// - busy   out  1              1 while state==OWN
// BEHAVIOUR
// - One clock domain; reset is synchronous, active-high.
// - Reset values: state=IDLE, gnt=0, q=0, q_bar=all-ones, busy=0, ptr=0, cnt=0, owner=0.
// - rst has priority over every other event on the same edge, including mid-grant.
// - Two-state FSM, IDLE and OWN:
//   - IDLE, req==0: hold; q is unchanged.
//   - IDLE, req!=0: winner = first set bit scanning ptr, ptr+1, ... mod N_REQ.
//     Next edge: gnt<=onehot(winner), owner<=winner, cnt<=0, state<=OWN.
//   - OWN, req[owner]==1: q<=wdata[owner], cnt<=cnt+1.
//     If cnt+1==HOLD_MAX, release on the same edge.
//   - OWN, req[owner]==0: no load; release.
//   - Release: gnt<=0, state<=IDLE, ptr<=(owner+1) mod N_REQ (wrap at N_REQ-1 -> 0).
// - Timing:
//   - Grant latency: req seen at edge k -> gnt visible after k; first load at edge k+1.
//   - At least one IDLE cycle between grants, so no back-to-back ownership.
//   - A continuous requester re-wins only after the others have been scanned.
// - req bits of non-owners are ignored during OWN; wdata of non-owners never reaches q.
// - cnt width = clog2(HOLD_MAX+1); it never exceeds HOLD_MAX.
// - q_bar is driven from the same register (~q); no separate state.
// STRUCTURE
// - Package arb_pkg:
//   - state localparams ST_IDLE=1'b0, ST_OWN=1'b1
//   - clog2 helper function
// - Sub-module rr_pick (combinational): inputs req, ptr; outputs winner index and valid.
//   Rotate, then priority-encode.
// - Top: FSM, ptr/owner/cnt registers, wdata mux, DATA_W-bit data register.
// TESTING
// - Reset: rst=1 for 2 edges -> gnt=0000, q=0x00, q_bar=0xFF, busy=0.
// - Single requester: req=0100, wdata[2]=0xA5 held 2 cycles then dropped.
//   -> gnt=0100 one cycle after req; q=0xA5 next edge; gnt=0000 after req drops; next ptr=3.
// - All requesting continuously, wdata[i]=0x10+i:
//   -> grants in order 0,1,2,3,0; each exactly 4 loads, 1 idle cycle between grants.
// - Wrap: owner 3 releases, then req=1001 -> gnt=0001 (ptr wrapped to 0), not 1000.
// - Reset mid-OWN: owner 1 after 2 loads of 0x3C, rst=1 for one edge
//   -> gnt=0000, q=0x00, ptr=0; the next grant follows the normal IDLE rules.
// - Early drop, HOLD_MAX=4: owner 2 drops req after 1 load of 0x77
//   -> q stays 0x77, gnt=0000 next edge, non-owner wdata never appears on q.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin register arbiter.
package arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_e;

    // Ceiling log2, with a floor of 1 bit so that index/counter vectors are never zero-width.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << r) < value) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_reg_arbiter_if.sv
// Request/data bus between the requesters and the shared-register arbiter.
interface rr_reg_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] wdata;
    logic [N_REQ-1:0]        gnt;
    logic [DATA_W-1:0]       q;
    logic [DATA_W-1:0]       q_bar;
    logic                    busy;

    modport master (
        output req, wdata,
        input  gnt, q, q_bar, busy
    );

    modport slave (
        input  req, wdata,
        output gnt, q, q_bar, busy
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate req so ptr lands at bit 0, then take the lowest set bit.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] winner_o,
    output logic             valid_o
);

    logic [N_REQ-1:0] rot_vec;

    always_comb begin : rotate
        int j;
        rot_vec = '0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(ptr_i) + i;
            if (j >= N_REQ) j = j - N_REQ;
            rot_vec[i] = req_i[j];
        end
    end

    // Scan from the highest offset down so the smallest offset from ptr wins.
    always_comb begin : encode
        int w;
        w       = 0;
        valid_o = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot_vec[i]) begin
                valid_o = 1'b1;
                w       = int'(ptr_i) + i;
                if (w >= N_REQ) w = w - N_REQ;
            end
        end
        winner_o = IDX_W'(w);
    end

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter that serialises writes from N_REQ requesters into one shared register.
module rr_reg_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    rr_reg_arbiter_if.slave   bus
);

    localparam int IDX_W = clog2(N_REQ);
    localparam int CNT_W = clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_REQ - 1);

    state_e              state_q, state_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    cnt_inc;

    logic [IDX_W-1:0]    pick_winner;
    logic                pick_valid;
    logic [DATA_W-1:0]   wdata_arr [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_wdata
            assign wdata_arr[gi] = bus.wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i    (bus.req),
        .ptr_i    (ptr_q),
        .winner_o (pick_winner),
        .valid_o  (pick_valid)
    );

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    gnt_d              = '0;
                    gnt_d[pick_winner] = 1'b1;
                    owner_d            = pick_winner;
                    cnt_d              = '0;
                    state_d            = ST_OWN;
                end
            end
            ST_OWN: begin
                // A dropped request or an exhausted hold budget both end ownership on this edge.
                if (bus.req[owner_q]) begin
                    data_d = wdata_arr[owner_q];
                    cnt_d  = cnt_inc;
                end
                if (!bus.req[owner_q] || (cnt_inc == HOLD_LAST)) begin
                    gnt_d   = '0;
                    state_d = ST_IDLE;
                    ptr_d   = (owner_q == IDX_LAST) ? '0 : owner_q + IDX_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            data_q  <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.q     = data_q;
    assign bus.q_bar = ~data_q;
    assign bus.busy  = (state_q == ST_OWN);

endmodule
